// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state type; also used by the receive-side bit sampler.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the host-side source (master) and the UART transmitter (slave).
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_in;
    logic                      data_valid;
    logic                      ready;

    modport master (output data_in, output data_valid, input ready);
    modport slave  (input data_in, input data_valid, output ready);

endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: bit_end strobes on the last clk cycle of each CLKS_PER_BIT-long bit.
module uart_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_end
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] LastTick = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] tick_q;

    // Wrapping on bit_end coincides with every FSM state change outside IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q <= '0;
        end else if (clear || bit_end) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + CntW'(1);
        end
    end

    assign bit_end = !clear && (tick_q == LastTick);

endmodule

// File: rtl/uart_tx.sv
// UART 8-N-1 serializer, LSB first, registered glitch-free tx.
// Define UART_TX_PARITY_EN to insert a parity bit (sense PARITY_ODD) between bit 7 and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      tx_done
);

    uart_tx_state_t            state_q;
    logic [UART_DATA_BITS-1:0] shreg_q;
    logic [2:0]                bit_idx_q;
    logic                      ready_q;
    logic                      tx_q;
    logic                      tx_done_q;
    logic                      bit_end;
    logic                      timer_clear;

`ifdef UART_TX_PARITY_EN
    logic parity_q;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    assign timer_clear = (state_q == IDLE);

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            ready_q   <= 1'b0;
            tx_q      <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.data_valid && ready_q) begin
                        state_q   <= START;
                        shreg_q   <= bus.data_in;
                        bit_idx_q <= '0;
                        ready_q   <= 1'b0;
                        tx_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= (^bus.data_in) ^ PARITY_ODD;
`endif
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shreg_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_q      <= parity_q;
`else
                            state_q   <= STOP;
                            tx_q      <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shreg_q   <= shreg_q >> 1;
                            tx_q      <= shreg_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_q   <= IDLE;
                        tx_done_q <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign tx        = tx_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bytes are queued on accept and compared against decoded frames.
// Honours UART_TX_PARITY_EN for frame length and the parity-bit scenario.
module tb_uart_tx;

    localparam int unsigned CPB        = 16;
    localparam bit          PARITY_ODD = 1'b0;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic tx_done;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .tx     (tx),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int c);
        int bitn;
        bitn = c / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
`ifdef UART_TX_PARITY_EN
        if (bitn == 9) return (^b) ^ PARITY_ODD;
`endif
        return 1'b1;
    endfunction

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!bus.ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.ready, 1'b1);
    endtask

    // Returns at the negedge of cycle 0 (first start-bit cycle).
    task automatic send(input logic [7:0] b, input bit hold);
        wait_ready(4 * FRAME_LEN);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        exp_q.push_back(b);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.data_valid = 1'b0;
    endtask

    // Called at the negedge of frame cycle 0; returns at the negedge of cycle FRAME_LEN.
    task automatic watch_frame();
        logic [7:0] exp_b;
        logic [7:0] rx_b;
        int bitn;
        rx_b = '0;
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        for (int c = 0; c <= FRAME_LEN; c++) begin
            if (c > 0) @(negedge clk);
            if (c < FRAME_LEN) begin
                check($sformatf("tx c%0d", c), tx, exp_level(exp_b, c));
                check($sformatf("ready_busy c%0d", c), bus.ready, 1'b0);
                check($sformatf("done_low c%0d", c), tx_done, 1'b0);
                bitn = c / CPB;
                if ((c % CPB) == CPB / 2 && bitn >= 1 && bitn <= 8) rx_b[bitn-1] = tx;
            end else begin
                check("done_pulse", tx_done, 1'b1);
                check("ready_at_done", bus.ready, 1'b1);
                check("tx_idle_at_done", tx, 1'b1);
            end
        end
        check("rx_byte", rx_b, exp_b);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held with a byte offered
        rst            = 1'b0;
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_ready", bus.ready, 1'b0);
            check("rst_done", tx_done, 1'b0);
        end

        // 2: release, ready after one edge, send A5
        bus.data_valid = 1'b0;
        rst            = 1'b1;
        check("ready_pre_edge", bus.ready, 1'b0);
        @(negedge clk);
        check("ready_after_rst", bus.ready, 1'b1);
        send(8'hA5, 1'b0);
        watch_frame();

        // 3: back-to-back with valid held; second start at cycle FRAME_LEN+1
        @(negedge clk);
        send(8'h00, 1'b1);
        bus.data_in = 8'hFF;
        exp_q.push_back(8'hFF);
        watch_frame();
        @(negedge clk);
        bus.data_valid = 1'b0;
        watch_frame();

        // 4: data_in change and valid pulse mid-frame are ignored
        @(negedge clk);
        send(8'h3C, 1'b0);
        fork
            watch_frame();
            begin
                repeat (40) @(negedge clk);
                bus.data_in    = 8'hC3;
                bus.data_valid = 1'b1;
                @(negedge clk);
                bus.data_valid = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_second_tx", tx, 1'b1);
            check("no_second_ready", bus.ready, 1'b1);
        end
        check("sb_drained", exp_q.size(), 0);

        // 5: asynchronous reset mid-frame, then a clean 55 frame
        send(8'h00, 1'b0);
        repeat (50) @(negedge clk);
        check("pre_rst_tx", tx, 1'b0);
        rst = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_ready", bus.ready, 1'b0);
        check("async_rst_done", tx_done, 1'b0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", bus.ready, 1'b1);
        send(8'h55, 1'b0);
        watch_frame();

`ifdef UART_TX_PARITY_EN
        // 6: even parity of 07 is 1 during cycles 144..159
        @(negedge clk);
        send(8'h07, 1'b0);
        watch_frame();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
